// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling FSM, show-ahead buffer, sticky error flags.
// Define ANTHILL_UART_RX_FIFO_EN for a g_fifo_depth-entry FIFO; otherwise a single holding register.
module uart_rx_fifo #(
  parameter int g_clks_per_bit = 868,
  parameter int g_fifo_depth   = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          uart_rxd_i,
  output logic [7:0]                    rx_data_o,
  output logic                          rx_valid_o,
  input  logic                          rx_ready_i,
  output logic [$clog2(g_fifo_depth):0] rx_level_o,
  output logic                          frame_err_o,
  output logic                          overrun_o,
  input  logic                          err_clr_i,
  output logic                          irq_o
);
  localparam int CW = $clog2(g_clks_per_bit);
  localparam int LW = $clog2(g_fifo_depth) + 1;
  localparam logic [CW-1:0] HALF_BIT = CW'(g_clks_per_bit / 2 - 1);
  localparam logic [CW-1:0] FULL_BIT = CW'(g_clks_per_bit - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  logic          r_rxd_meta, r_rxd_s;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          w_sample, w_push, w_frame_set, w_pop, w_full, w_ovr_set;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rxd_meta <= 1'b1;
      r_rxd_s    <= 1'b1;
    end else begin
      r_rxd_meta <= uart_rxd_i;
      r_rxd_s    <= r_rxd_meta;
    end
  end

  assign w_sample    = (r_cnt == '0);
  assign w_push      = (r_state == S_STOP) && w_sample && r_rxd_s;
  assign w_frame_set = (r_state == S_STOP) && w_sample && !r_rxd_s;
  assign w_pop       = rx_valid_o && rx_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!r_rxd_s) begin
            r_state <= S_START;
            r_cnt   <= HALF_BIT;
          end
        end
        S_START: begin
          if (w_sample) begin
            if (!r_rxd_s) begin
              r_state   <= S_DATA;
              r_cnt     <= FULL_BIT;
              r_bit_idx <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (w_sample) begin
            r_shift   <= {r_rxd_s, r_shift[7:1]};
            r_cnt     <= FULL_BIT;
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_STOP: begin
          if (w_sample) r_state <= r_rxd_s ? S_IDLE : S_BREAK;
          else          r_cnt   <= r_cnt - 1'b1;
        end
        S_BREAK: begin
          // Held-low line: wait for the line to return high before hunting for a start bit.
          if (r_rxd_s) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ANTHILL_UART_RX_FIFO_EN
  localparam int AW = $clog2(g_fifo_depth);

  logic [7:0]  r_mem [g_fifo_depth];
  logic [AW:0] r_wr_ptr, r_rd_ptr;
  logic        w_wr_en;

  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign rx_valid_o = (r_wr_ptr != r_rd_ptr);
  assign w_wr_en    = w_push && (!w_full || w_pop);
  assign w_ovr_set  = w_push && w_full && !w_pop;
  assign rx_data_o  = r_mem[r_rd_ptr[AW-1:0]];
  assign rx_level_o = LW'(r_wr_ptr - r_rd_ptr);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < g_fifo_depth; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end
`else
  logic       r_hold_vld;
  logic [7:0] r_hold_data;

  assign w_full     = r_hold_vld;
  assign w_ovr_set  = w_push && w_full && !w_pop;
  assign rx_valid_o = r_hold_vld;
  assign rx_data_o  = r_hold_data;
  assign rx_level_o = LW'(r_hold_vld);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hold_vld  <= 1'b0;
      r_hold_data <= '0;
    end else if (w_push && (!w_full || w_pop)) begin
      r_hold_vld  <= 1'b1;
      r_hold_data <= r_shift;
    end else if (w_pop) begin
      r_hold_vld  <= 1'b0;
    end
  end
`endif

  // Set has priority over clear so an error in the clearing cycle is not lost.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      if (w_frame_set)    frame_err_o <= 1'b1;
      else if (err_clr_i) frame_err_o <= 1'b0;
      if (w_ovr_set)      overrun_o   <= 1'b1;
      else if (err_clr_i) overrun_o   <= 1'b0;
    end
  end

  assign irq_o = rx_valid_o | frame_err_o | overrun_o;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: table of single-frame vectors plus hand-written corner sequences.
module tb_uart_rx_fifo;
  localparam int CPB   = 16;
  localparam int DEPTH = 16;
`ifdef ANTHILL_UART_RX_FIFO_EN
  localparam int CAP = DEPTH;
`else
  localparam int CAP = 1;
`endif

  logic       clk = 1'b0, rst = 1'b1, rxd = 1'b1, ready = 1'b0, err_clr = 1'b0;
  logic [7:0] data;
  logic       valid, ferr, ovr, irq;
  logic [4:0] level;
  int         errors = 0, checks = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  uart_rx_fifo #(.g_clks_per_bit(CPB), .g_fifo_depth(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .uart_rxd_i(rxd),
    .rx_data_o(data), .rx_valid_o(valid), .rx_ready_i(ready), .rx_level_o(level),
    .frame_err_o(ferr), .overrun_o(ovr), .err_clr_i(err_clr), .irq_o(irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, " valid"}, valid, 0);
    check({name, " data"},  data,  0);
    check({name, " level"}, level, 0);
    check({name, " ferr"},  ferr,  0);
    check({name, " ovr"},   ovr,   0);
    check({name, " irq"},   irq,   0);
  endtask

  // One 8N1 frame; ready pulses at frame clock pop_at, reset held for 4 clocks from rst_at.
  task automatic send(input logic [7:0] d, input logic stop, input int pop_at, input int rst_at);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int t = 0; t < 10 * CPB; t++) begin
      @(negedge clk);
      rxd   = fr[t / CPB];
      ready = (t == pop_at);
      if (rst_at >= 0 && t == rst_at + 2) check_all_zero("reset mid-frame");
      rst = (rst_at >= 0 && t >= rst_at && t < rst_at + 4);
    end
  endtask

  task automatic line(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rxd   = v;
      ready = 1'b0;
    end
  endtask

  task automatic pop_one();
    @(negedge clk); ready = 1'b1;
    @(negedge clk); ready = 1'b0;
  endtask

  task automatic clr_err();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
  endtask

  task automatic drain_check(input string name);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      check({name, " valid"}, valid, 1);
      check({name, " data"},  data,  exp_q.pop_front());
      ready = 1'b1;
    end
    @(negedge clk);
    ready = 1'b0;
    check({name, " empty valid"}, valid, 0);
    check({name, " empty level"}, level, 0);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
    vecs[3] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 1'b0};

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    line(1'b1, 2 * CPB);

    foreach (vecs[i]) begin
      send(vecs[i].d, vecs[i].stop, -1, -1);
      line(1'b1, 2 * CPB);
      check($sformatf("vec%0d valid", i), valid, vecs[i].exp_valid);
      check($sformatf("vec%0d level", i), level, vecs[i].exp_valid ? 1 : 0);
      check($sformatf("vec%0d ferr", i),  ferr,  vecs[i].exp_ferr);
      check($sformatf("vec%0d ovr", i),   ovr,   0);
      check($sformatf("vec%0d irq", i),   irq,   1);
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d data", i), data, vecs[i].exp_data);
        pop_one();
        check($sformatf("vec%0d level after pop", i), level, 0);
        check($sformatf("vec%0d irq after pop", i),   irq,   0);
      end else begin
        clr_err();
        check($sformatf("vec%0d ferr cleared", i), ferr, 0);
        check($sformatf("vec%0d irq cleared", i),  irq,  0);
      end
    end

    // Overrun: CAP+1 bytes with no pops; last is dropped.
    for (int i = 0; i <= CAP; i++) send(8'(i), 1'b1, -1, -1);
    line(1'b1, 4);
    check("overrun level", level, CAP);
    check("overrun flag",  ovr,   1);
    check("overrun irq",   irq,   1);
    for (int i = 0; i < CAP; i++) exp_q.push_back(8'(i));
    drain_check("overrun drain");
    check("overrun still set", ovr, 1);
    clr_err();
    check("overrun cleared", ovr, 0);

    // Framing error followed by a held-low line.
    send(8'h3C, 1'b0, -1, -1);
    line(1'b0, 40);
    check("frame err flag",  ferr,  1);
    check("frame err level", level, 0);
    line(1'b1, 2 * CPB);
    check("break no bytes",  level, 0);
    send(8'h55, 1'b1, -1, -1);
    line(1'b1, 4);
    check("after break level", level, 1);
    check("after break data",  data,  8'h55);
    pop_one();
    clr_err();
    check("after break ferr cleared", ferr, 0);

    // Glitch rejection: 4-clock low pulse.
    line(1'b0, 4);
    line(1'b1, 3 * CPB);
    check("glitch level", level, 0);
    check("glitch ferr",  ferr,  0);
    check("glitch ovr",   ovr,   0);
    send(8'h81, 1'b1, -1, -1);
    line(1'b1, 4);
    check("post glitch level", level, 1);
    check("post glitch data",  data,  8'h81);
    pop_one();

    // Full with a pop in the push cycle (push lands at frame clock 155).
    for (int i = 0; i < CAP; i++) send(8'hB0 + 8'(i), 1'b1, -1, -1);
    send(8'hEE, 1'b1, 154, -1);
    line(1'b1, 4);
    check("full pop level", level, CAP);
    check("full pop ovr",   ovr,   0);
    for (int i = 1; i < CAP; i++) exp_q.push_back(8'hB0 + 8'(i));
    exp_q.push_back(8'hEE);
    drain_check("full pop drain");

    // Reset during bit 4 of 0xF0 with a byte already buffered.
    send(8'h11, 1'b1, -1, -1);
    send(8'hF0, 1'b1, -1, 5 * CPB + 8);
    line(1'b1, 10 * CPB);
    check("post reset empty", level, 0);
    send(8'h42, 1'b1, -1, -1);
    line(1'b1, 4);
    check("post reset level", level, 1);
    check("post reset data",  data,  8'h42);
    check("post reset ferr",  ferr,  0);
    pop_one();
    check("post reset drained", level, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive half of the anthill serial console. It takes the raw `uart_rxd_i` pin from the top level and oversamples it in the system clock domain. Each 8N1 frame is deserialised into a byte and buffered in a show-ahead FIFO, which the RISC-V core's peripheral bus drains over a valid/ready handshake. Framing and overrun faults are latched into sticky flags, and a single interrupt line is exported to the core.

## Interface
- `g_clks_per_bit`, 868: system clocks per bit; 100 MHz / 115200. Even, ≥ 8.
- `g_fifo_depth`, 16: FIFO entries; power of two, ≥ 2.
- `clk_i` in 1: system clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `uart_rxd_i` in 1: asynchronous serial line; idles high.
- `rx_data_o` out 8: FIFO head byte; valid only while `rx_valid_o` is high.
- `rx_valid_o` out 1: FIFO not empty.
- `rx_ready_i` in 1: consumer pops the head when this and `rx_valid_o` are both high.
- `rx_level_o` out $clog2(g_fifo_depth)+1: current FIFO occupancy.
- `frame_err_o` out 1: sticky; a stop bit was sampled low.
- `overrun_o` out 1: sticky; a byte was dropped because the FIFO was full.
- `err_clr_i` in 1: clears both sticky flags.
- `irq_o` out 1: interrupt to the core.

## Operation
- **Synchroniser**
  - Two flops on `uart_rxd_i`; both reset to 1.
  - The FSM sees only the second flop, `rxd_s`.
- **FSM states:** IDLE, START, DATA, STOP, BREAK. Bit counter `cnt` counts down; every sample is taken in the cycle `cnt==0`.
  - **IDLE:** when `rxd_s==0`, go to START and load `cnt = g_clks_per_bit/2 - 1`.
  - **START:** at `cnt==0`:
    - `rxd_s==0`: go to DATA, load `cnt = g_clks_per_bit - 1`, clear the bit index.
    - `rxd_s==1`: treat as a glitch and return to IDLE. Nothing is pushed and no flag is set.
  - **DATA:** at each `cnt==0`, shift `rxd_s` in LSB first and reload `cnt`. After bit 7, go to STOP with `cnt` reloaded.
  - **STOP:** at `cnt==0`:
    - `rxd_s==1`: push the byte and go to IDLE.
    - `rxd_s==0`: discard the byte, set `frame_err_o`, go to BREAK.
  - **BREAK:** stay until `rxd_s==1`, then go to IDLE. This stops a held-low line (break condition) from producing frames.
- **FIFO**
  - Show-ahead: `rx_data_o` always presents the head entry.
  - Push when full with no pop in the same cycle: the byte is dropped, `overrun_o` is set, FIFO contents are unchanged.
  - Push and pop in the same cycle, including when full: both take effect and the level is unchanged. No overrun is flagged.
  - Pop while empty is ignored.
  - Read and write pointers wrap modulo `g_fifo_depth`. Occupancy is tracked with an extra pointer bit.
- **Sticky flags**
  - `err_clr_i` clears both flags.
  - If a set event occurs in the same cycle as `err_clr_i`, the set wins.
- **Interrupt:** `irq_o = rx_valid_o | frame_err_o | overrun_o`, combinational from registered state.
- **Reset**
  - The FSM goes to IDLE, the FIFO is emptied, and both flags are cleared.
  - A reset in the middle of a frame discards the partial byte. The remainder of that frame is then parsed from IDLE. Any spurious byte that results is acceptable and is flagged by normal rules only.

## Timing
- Reset values: `rx_data_o = 0`, `rx_valid_o = 0`, `rx_level_o = 0`, `frame_err_o = 0`, `overrun_o = 0`, `irq_o = 0`.
- Falling edge on the pin to the FSM leaving IDLE: 3 clocks (2 synchroniser flops plus 1 FSM register).
- Stop-bit sample to push: the push happens on the clock edge ending the `cnt==0` cycle. `rx_valid_o` and `rx_level_o` update in the next cycle, so latency is 1 clock.
- Pop: `rx_data_o`, `rx_valid_o` and `rx_level_o` reflect the new head in the cycle after `rx_valid_o & rx_ready_i`. The consumer can sustain one pop per clock.
- Sample points fall at mid-bit, ±1 clock.
- The receiver is ready for the next start bit while still in the second half of the stop bit.

## Configuration
- `ANTHILL_UART_RX_FIFO_EN` defined: the FIFO is built with `g_fifo_depth` entries.
- Not defined: the FIFO is replaced by a single holding register.
  - `g_fifo_depth` is ignored.
  - `rx_level_o` is 0 or 1.
  - Overrun is set when a byte arrives while the register is still full and not being popped in that cycle.
  - All other behaviour is identical.

## Test plan
All scenarios use `g_clks_per_bit = 16` and `g_fifo_depth = 16`.
- **Single byte:** send 0xA5, `rx_ready_i = 0`. Expect `rx_valid_o = 1`, `rx_data_o = 0xA5`, `rx_level_o = 1`, `irq_o = 1`. Pulse `rx_ready_i` for 1 cycle; expect `rx_level_o = 0` and `irq_o = 0`.
- **Overrun:** send 17 bytes 0x00..0x10 back to back with no pops.
  - Expect `rx_level_o = 16` and `overrun_o = 1`.
  - Draining yields exactly 0x00..0x0F.
  - Then assert `err_clr_i`; expect `overrun_o = 0`.
- **Framing error:** send 0x3C with the stop bit low, then hold the line low for 40 clocks, then send 0x55.
  - Expect `frame_err_o = 1` and no push from the bad frame.
  - The line held low produces no extra bytes.
  - 0x55 is received correctly.
- **Glitch rejection:** a 4-clock low pulse on an idle line produces no push, no flag, and the FSM returns to IDLE. A following byte 0x81 is received correctly.
- **Full with simultaneous pop:** fill to 16 entries, then assert `rx_ready_i` in the cycle the 17th byte pushes.
  - Expect `rx_level_o` to stay 16 and `overrun_o = 0`.
  - The 17th byte is present as the last entry when the FIFO is drained.
- **Reset mid-frame:** assert `rst_i` during bit 4 of 0xF0.
  - All outputs read 0 while `rst_i` is high.
  - After release, an idle-line gap of 10 bit times followed by byte 0x42 yields exactly one byte, 0x42.
